// File: rtl/span_pkg.sv
// span_pkg: shared constants and types for the SPAN scan engine.
// Scenario moves are signed fractions of the price scan range in 1/128 units.
package span_pkg;
  localparam int NUM_SCEN    = 16;
  localparam int SCALE_SHIFT = 7;

  // Pairs are vol-up/vol-down; 15/16 are the 3x extremes weighted 33%.
  localparam logic signed [8:0] SCAN_MOVE [1:16] = '{
    9'sd0,    9'sd0,
    9'sd42,   9'sd42,
    -9'sd42,  -9'sd42,
    9'sd86,   9'sd86,
    -9'sd86,  -9'sd86,
    9'sd128,  9'sd128,
    -9'sd128, -9'sd128,
    9'sd127,  -9'sd127
  };

  typedef enum logic [1:0] {
    S_IDLE,
    S_SUM,
    S_SCAN,
    S_DONE
  } state_e;
endpackage

// File: rtl/span_pos_sum.sv
// span_pos_sum: signed sum of NPOS positions, sign-extended to WN bits.
// WN leaves room for the full carry growth of the sum.
module span_pos_sum
  import span_pkg::*;
#(
  parameter int NPOS  = 8,
  parameter int W_POS = 16,
  parameter int WN    = W_POS + $clog2(NPOS)
) (
  input  logic signed [W_POS-1:0] pos [0:NPOS-1],
  output logic signed [WN-1:0]    net
);

  always_comb begin
    net = '0;
    for (int i = 0; i < NPOS; i++) begin
      net = net + WN'(pos[i]);
    end
  end

endmodule

// File: rtl/span_scan_engine.sv
// span_scan_engine: sequential SPAN scanning-risk engine, one scenario per
// cycle on a single shared multiplier; reports floored, saturated worst loss.
module span_scan_engine
  import span_pkg::*;
#(
  parameter int NPOS  = 8,
  parameter int W_POS = 16,
  parameter int W_PSR = 16,
  parameter int W_OUT = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [W_PSR-1:0]        psr,
  input  logic signed [W_POS-1:0] position [0:NPOS-1],
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [W_OUT-1:0]        scan_risk,
  output logic [4:0]              worst_scen,
  output logic                    out_sat
);

  localparam int WN  = W_POS + $clog2(NPOS);
  localparam int WNP = WN + W_PSR + 1;
  localparam int WL  = WN + W_PSR + 9;
  localparam int WR  = WL - SCALE_SHIFT;

  state_e                  state_q, state_d;
  logic [W_PSR-1:0]        psr_q, psr_d;
  logic signed [W_POS-1:0] pos_q [0:NPOS-1];
  logic signed [W_POS-1:0] pos_d [0:NPOS-1];
  logic signed [WNP-1:0]   netpsr_q, netpsr_d;
  logic signed [WL-1:0]    best_q, best_d;
  logic [4:0]              k_q, k_d;
  logic [4:0]              idx_q, idx_d;
  logic                    in_ready_q, in_ready_d;
  logic                    out_valid_q, out_valid_d;
  logic [W_OUT-1:0]        risk_q, risk_d;
  logic [4:0]              scen_q, scen_d;
  logic                    sat_q, sat_d;

  logic signed [WN-1:0]    net_w;
  logic signed [WL-1:0]    op_a, op_b, mul, loss, best_n;
  logic [WR-1:0]           r_w;
  logic                    upd, r_sat;

  span_pos_sum #(
    .NPOS  (NPOS),
    .W_POS (W_POS),
    .WN    (WN)
  ) u_sum (
    .pos (pos_q),
    .net (net_w)
  );

  // SUM forms net*psr, SCAN forms (net*psr)*m_k on the same multiplier.
  always_comb begin
    if (state_q == S_SUM) begin
      op_a = WL'(net_w);
      op_b = WL'({1'b0, psr_q});
    end else begin
      op_a = WL'(netpsr_q);
      op_b = WL'(SCAN_MOVE[k_q]);
    end
  end

  assign mul    = op_a * op_b;
  assign loss   = -mul;
  assign upd    = loss > best_q;
  assign best_n = upd ? loss : best_q;
  assign r_w    = best_n[WL-1:SCALE_SHIFT];
  assign r_sat  = |r_w[WR-1:W_OUT];

  always_comb begin
    state_d     = state_q;
    psr_d       = psr_q;
    pos_d       = pos_q;
    netpsr_d    = netpsr_q;
    best_d      = best_q;
    k_d         = k_q;
    idx_d       = idx_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    risk_d      = risk_q;
    scen_d      = scen_q;
    sat_d       = sat_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          psr_d      = psr;
          pos_d      = position;
          in_ready_d = 1'b0;
          state_d    = S_SUM;
        end
      end
      S_SUM: begin
        netpsr_d = mul[WNP-1:0];
        best_d   = '0;
        idx_d    = '0;
        k_d      = 5'd1;
        if (net_w == '0) begin
          risk_d      = '0;
          scen_d      = '0;
          sat_d       = 1'b0;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        best_d = best_n;
        if (upd) idx_d = k_q;
        k_d = k_q + 5'd1;
        if (k_q == 5'(NUM_SCEN)) begin
          risk_d      = r_sat ? '1 : r_w[W_OUT-1:0];
          sat_d       = r_sat;
          scen_d      = idx_d;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      psr_q       <= '0;
      pos_q       <= '{default: '0};
      netpsr_q    <= '0;
      best_q      <= '0;
      k_q         <= '0;
      idx_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      risk_q      <= '0;
      scen_q      <= '0;
      sat_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      psr_q       <= psr_d;
      pos_q       <= pos_d;
      netpsr_q    <= netpsr_d;
      best_q      <= best_d;
      k_q         <= k_d;
      idx_q       <= idx_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      risk_q      <= risk_d;
      scen_q      <= scen_d;
      sat_q       <= sat_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign scan_risk  = risk_q;
  assign worst_scen = scen_q;
  assign out_sat    = sat_q;

endmodule

// File: tb/tb_span_scan_engine.sv
// tb_span_scan_engine: table vectors, randomized requests against a
// scenario-level reference model, plus backpressure and reset sequences.
`timescale 1ns/1ps
module tb_span_scan_engine;

  typedef logic signed [15:0] pos_t [0:7];

  typedef struct {
    logic [15:0] psr;
    pos_t        pos;
    longint      risk;
    int          scen;
    bit          sat;
    int          lat;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] psr = '0;
  pos_t        position;
  logic        in_ready, out_valid, out_sat;
  logic [15:0] scan_risk;
  logic [4:0]  worst_scen;

  int checks = 0;
  int failures = 0;

  int mv [1:16] = '{0, 0, 42, 42, -42, -42, 86, 86,
                    -86, -86, 128, 128, -128, -128, 127, -127};

  always #5 clk = ~clk;

  span_scan_engine #(
    .NPOS  (8),
    .W_POS (16),
    .W_PSR (16),
    .W_OUT (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .psr        (psr),
    .position   (position),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .scan_risk  (scan_risk),
    .worst_scen (worst_scen),
    .out_sat    (out_sat)
  );

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  function automatic longint net_of(input pos_t pv);
    longint n = 0;
    foreach (pv[i]) n += longint'(pv[i]);
    return n;
  endfunction

  // Worst loss over the 16 scenarios, floored at zero, /128, clipped.
  function automatic void model(input logic [15:0] p, input pos_t pv,
                                output longint risk, output int scen,
                                output bit sat);
    longint net = net_of(pv);
    longint best = 0;
    longint loss;
    scen = 0;
    for (int k = 1; k <= 16; k++) begin
      loss = -(net * longint'(p) * longint'(mv[k]));
      if (loss > best) begin
        best = loss;
        scen = k;
      end
    end
    risk = best / 128;
    sat = risk > 65535;
    if (sat) risk = 65535;
  endfunction

  // Entered and left at a negedge.
  task automatic run_req(input logic [15:0] p, input pos_t pv, input int hold,
                         output int lat, output longint risk,
                         output int scen, output bit sat);
    int w = 0;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("accept_ready", in_ready, 1);
    psr = p;
    position = pv;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    psr = 16'($urandom);
    foreach (position[i]) position[i] = 16'($urandom);
    lat = 1;
    while (!out_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    chk("got_valid", out_valid, 1);
    chk("busy_ready", in_ready, 0);
    risk = scan_risk;
    scen = worst_scen;
    sat = out_sat;
    repeat (hold) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("ready_after", in_ready, 1);
    chk("valid_after", out_valid, 0);
  endtask

  initial begin
    vec_t   tv[$];
    vec_t   v;
    pos_t   pv;
    int     lat, s, es, hold, mode;
    longint r, er;
    bit     st, est;

    foreach (position[i]) position[i] = '0;

    // Reset state
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_risk", scan_risk, 0);
    chk("rst_scen", worst_scen, 0);
    chk("rst_sat", out_sat, 0);
    reset = 1'b1;
    @(negedge clk);

    // Table vectors
    v.psr = 100; foreach (v.pos[i]) v.pos[i] = 1;
    v.risk = 800; v.scen = 13; v.sat = 0; v.lat = 18; tv.push_back(v);
    v.psr = 100; foreach (v.pos[i]) v.pos[i] = -1;
    v.risk = 800; v.scen = 11; v.sat = 0; v.lat = 18; tv.push_back(v);
    v.psr = 500; v.pos = '{5, -5, 3, -3, 0, 0, 7, -7};
    v.risk = 0; v.scen = 0; v.sat = 0; v.lat = 2; tv.push_back(v);
    v.psr = 65535; foreach (v.pos[i]) v.pos[i] = 32767;
    v.risk = 65535; v.scen = 13; v.sat = 1; v.lat = 18; tv.push_back(v);
    v.psr = 65535; foreach (v.pos[i]) v.pos[i] = -32768;
    v.risk = 65535; v.scen = 11; v.sat = 1; v.lat = 18; tv.push_back(v);
    v.psr = 0; foreach (v.pos[i]) v.pos[i] = 3;
    v.risk = 0; v.scen = 0; v.sat = 0; v.lat = 18; tv.push_back(v);
    v.psr = 1; v.pos = '{-1, 0, 0, 0, 0, 0, 0, 0};
    v.risk = 1; v.scen = 11; v.sat = 0; v.lat = 18; tv.push_back(v);
    v.psr = 65535; v.pos = '{1, 0, 0, 0, 0, 0, 0, 0};
    v.risk = 65535; v.scen = 13; v.sat = 0; v.lat = 18; tv.push_back(v);
    v.psr = 65535; v.pos = '{2, 0, 0, 0, 0, 0, 0, 0};
    v.risk = 65535; v.scen = 13; v.sat = 1; v.lat = 18; tv.push_back(v);
    v.psr = 7; v.pos = '{100, -300, 0, 0, 0, 0, 0, 0};
    v.risk = 1400; v.scen = 11; v.sat = 0; v.lat = 18; tv.push_back(v);

    foreach (tv[n]) begin
      run_req(tv[n].psr, tv[n].pos, 0, lat, r, s, st);
      chk($sformatf("vec%0d_risk", n), r, tv[n].risk);
      chk($sformatf("vec%0d_scen", n), s, tv[n].scen);
      chk($sformatf("vec%0d_sat", n), st, tv[n].sat);
      chk($sformatf("vec%0d_lat", n), lat, tv[n].lat);
    end

    // Randomized requests against the reference model
    for (int n = 0; n < 40; n++) begin
      mode = $urandom_range(0, 3);
      foreach (pv[i]) begin
        unique case (mode)
          0: pv[i] = 16'($urandom_range(0, 200)) - 16'sd100;
          1: pv[i] = 16'($urandom);
          2: pv[i] = (i < 4) ? 16'($urandom_range(0, 2000)) - 16'sd1000
                             : -pv[i - 4];
          default: pv[i] = (i == 0) ? 16'($urandom_range(0, 4)) - 16'sd2 : '0;
        endcase
      end
      psr = (n % 3 == 0) ? 16'($urandom_range(0, 50)) : 16'($urandom);
      hold = $urandom_range(0, 3);
      model(psr, pv, er, es, est);
      run_req(psr, pv, hold, lat, r, s, st);
      chk($sformatf("rnd%0d_risk", n), r, er);
      chk($sformatf("rnd%0d_scen", n), s, es);
      chk($sformatf("rnd%0d_sat", n), st, est);
      chk($sformatf("rnd%0d_lat", n), lat, (net_of(pv) == 0) ? 2 : 18);
    end

    // Backpressure: outputs hold, in_valid pulse dropped
    psr = 100;
    foreach (position[i]) position[i] = 1;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    chk("bp_valid", out_valid, 1);
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin
        in_valid = 1'b1;
        psr = 9;
        foreach (position[i]) position[i] = -1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      chk("bp_risk", scan_risk, 800);
      chk("bp_scen", worst_scen, 13);
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_ready_next", in_ready, 1);
    chk("bp_valid_next", out_valid, 0);
    repeat (3) begin
      @(negedge clk);
      chk("bp_dropped", in_ready, 1);
    end

    // Reset during SCAN at k=6
    psr = 100;
    foreach (position[i]) position[i] = 1;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("mid_busy", in_ready, 0);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("mid_valid", out_valid, 0);
    chk("mid_ready", in_ready, 1);
    chk("mid_risk", scan_risk, 0);
    chk("mid_scen", worst_scen, 0);
    chk("mid_sat", out_sat, 0);
    repeat (20) @(negedge clk);
    chk("mid_no_result", out_valid, 0);
    run_req(tv[1].psr, tv[1].pos, 1, lat, r, s, st);
    chk("post_rst_risk", r, 800);
    chk("post_rst_scen", s, 11);
    chk("post_rst_lat", lat, 18);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/span_scan_engine.md
# span_scan_engine

Parametrised sequential SPAN scanning-risk engine for futures portfolios. It accepts a batch of NPOS signed positions and a price scan range over a valid/ready handshake. It sums the positions and walks the full 16-scenario SPAN risk array one scenario per cycle on a single shared multiplier. It returns the worst-case loss, floored at zero, together with the index of the scenario that produced it. It sits downstream of the position loader and upstream of the inter-commodity spread/margin aggregation stage. Short portfolios are handled correctly, and the output saturates.

## Interface
- NPOS, 8: number of position inputs (≥2).
- W_POS, 16: position width, signed two's complement.
- W_PSR, 16: price scan range width, unsigned, in price ticks.
- W_OUT, 16: scan_risk width, unsigned.
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  reset, synchronous, active-low.
- in_valid  in  1  request valid.
- in_ready  out  1  engine idle and able to accept.
- psr  in  W_PSR  price scan range.
- position  in  NPOS×W_POS  signed positions, unpacked array [0:NPOS-1].
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- scan_risk  out  W_OUT  max(0, worst loss) / 128, saturated.
- worst_scen  out  5  1..16 = scenario giving the loss; 0 = no loss in any scenario.
- out_sat  out  1  scan_risk was clipped to all-ones.

## Operation
- States: IDLE, SUM, SCAN, DONE.
- IDLE: in_ready=1. On in_valid&in_ready, capture psr and every position, then go to SUM.
- SUM: net = signed sum of all positions, width WN = W_POS+$clog2(NPOS), registered.
  - net==0: go straight to DONE with best=0 and worst_scen=0.
  - Otherwise clear best=0 and idx=0, then go to SCAN.
- SCAN: scenario counter k = 1..16, one per cycle.
  - loss_k = −(net × psr × m_k). Compute it as a signed product of width WN+W_PSR+9 with no truncation.
  - If loss_k > best (strict): best ← loss_k, idx ← k. The lowest index therefore wins ties, and losses ≤0 never register.
  - After k=16, go to DONE.
- Move table m_k in 1/128 units, scenarios 1..16: 0, 0, +42, +42, −42, −42, +86, +86, −86, −86, +128, +128, −128, −128, +127, −127.
  - Paired entries correspond to vol-up/vol-down and are identical for futures.
  - 15/16 are the extreme moves: 3× range weighted 33%.
- DONE:
  - r = best >> 7 (best ≥0, floor).
  - If r > 2^W_OUT−1: scan_risk = all-ones and out_sat=1. Otherwise scan_risk = r and out_sat=0.
  - worst_scen = idx.
  - out_valid=1. All outputs hold stable until out_ready=1, then return to IDLE.
- Long portfolio: worst case is a down move. Short portfolio: worst case is an up move.

## Timing
- Reset (reset=0 on a clock edge): state=IDLE, in_ready=1, out_valid=0, scan_risk=0, worst_scen=0, out_sat=0, internal registers cleared.
- Reset takes priority in every state. It aborts an in-flight calculation, and the result is discarded.
- Acceptance at edge T:
  - SUM occupies T+1.
  - SCAN occupies T+2..T+17.
  - out_valid is high from T+18.
  - For net==0, out_valid is high from T+2.
- in_ready=0 from T+1 until the edge on which DONE hands off (out_valid&out_ready). in_ready=1 on the following cycle. There is no overlap of requests.
- in_valid while in_ready=0 is ignored and not queued.
- Input ports are sampled only at acceptance. Changes afterwards have no effect.
- Throughput: one result per 19 cycles minimum with out_ready held high.

## Structure
- Package span_pkg holds:
  - NUM_SCEN=16.
  - SCALE_SHIFT=7.
  - SCAN_MOVE[1:16], signed 9-bit move table.
  - State enum type.
- Sub-module span_pos_sum: parametrised (NPOS, W_POS) signed adder tree producing net, sign-extended to WN. It is instantiated once, and its output is registered in SUM.
- One multiplier (net×psr registered in SUM, × m_k in SCAN), one comparator, 5-bit scenario counter.

## Test plan
- NPOS=8, all positions +1, psr=100 → scan_risk=800, worst_scen=13, out_sat=0, out_valid 18 cycles after accept.
- All positions −1, psr=100 → scan_risk=800, worst_scen=11.
- Positions +5,−5,+3,−3,0,0,+7,−7, psr=500 → scan_risk=0, worst_scen=0, out_valid 2 cycles after accept.
- All positions +32767, psr=65535 → scan_risk=16'hFFFF, out_sat=1, worst_scen=13.
- Backpressure: complete a request with out_ready=0 for 5 cycles. Outputs stay stable, in_ready=0, and an in_valid pulse in that window is dropped. Raising out_ready gives a handoff, then in_ready=1 on the next cycle.
- Reset mid-operation: assert reset=0 during SCAN (k=6). The next cycle shows out_valid=0, in_ready=1 and all outputs 0. A new request then completes normally.
